// File: rtl/axi4_slave_ram.sv
// AXI4 memory-mapped slave backed by an on-chip RAM.
// Supports single-beat transfers and FIXED/INCR bursts of up to 256 beats.
// WRAP bursts are handled as INCR.
// Read and write channels are independent. Each direction allows one
// outstanding transaction.
// Optional build macro: AXI_SLAVE_RAM_DECERR_EN. When it is defined, any
// address with nonzero bits above the RAM range gets a DECERR response, and
// writes to such addresses are suppressed. When it is undefined, the upper
// address bits alias onto the RAM.
module axi4_slave_ram #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int MEM_DEPTH_WORDS    = 4096
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic [1:0]                      s_axi_awburst,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  input  logic [1:0]                      s_axi_arburst,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
);

  localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_DEPTH_WORDS);
  localparam int IDX_TOP  = ADDR_LSB + IDX_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [0:MEM_DEPTH_WORDS-1];

  w_state_t         w_state;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_len;
  logic [7:0]       w_beat;
  logic             w_fixed;
  logic             w_err;
  logic             mem_we;

  r_state_t         r_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_len;
  logic [7:0]       r_beat;
  logic             r_fixed;
  logic             r_err;

  logic             aw_err;
  logic             ar_err;

`ifdef AXI_SLAVE_RAM_DECERR_EN
  assign aw_err = |s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:IDX_TOP];
  assign ar_err = |s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:IDX_TOP];
  logic unused_bits;
  assign unused_bits = &{1'b0, s_axi_wlast,
                         s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
  logic unused_bits;
  assign unused_bits = &{1'b0, s_axi_wlast,
                         s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:IDX_TOP],
                         s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:IDX_TOP],
                         s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};
`endif

  // Gate RAM writes on the W handshake. Writes are dropped for an errored burst.
  always_comb begin
    mem_we = 1'b0;
    if (w_state == W_DATA && s_axi_wvalid && s_axi_wready && !w_err)
      mem_we = 1'b1;
  end

  // RAM write port with per-byte strobes. It is not reset, so contents survive reset.
  always_ff @(posedge ap_clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b])
          mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Write FSM: AW acceptance, data beats counted against len, then the B response.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= '0;
      w_idx         <= '0;
      w_len         <= '0;
      w_beat        <= '0;
      w_fixed       <= 1'b0;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_bid     <= s_axi_awid;
            w_idx         <= s_axi_awaddr[ADDR_LSB +: IDX_W];
            w_len         <= s_axi_awlen;
            w_fixed       <= (s_axi_awburst == 2'b00);
            w_err         <= aw_err;
            w_beat        <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid && s_axi_wready) begin
            // Termination follows the latched len; wlast is not consulted.
            if (w_beat == w_len) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= w_err ? 2'b11 : 2'b00;
              w_state      <= W_RESP;
            end else begin
              w_beat <= w_beat + 8'd1;
              if (!w_fixed)
                w_idx <= w_idx + 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: AR acceptance, then for each beat one fetch cycle and one present cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_fixed       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_rid     <= s_axi_arid;
            r_idx         <= s_axi_araddr[ADDR_LSB +: IDX_W];
            r_len         <= s_axi_arlen;
            r_fixed       <= (s_axi_arburst == 2'b00);
            r_err         <= ar_err;
            r_beat        <= '0;
            s_axi_arready <= 1'b0;
            r_state       <= R_FETCH;
          end
        end
        R_FETCH: begin
          // The RAM is sampled before this edge's write lands, so a same-word collision returns old data.
          s_axi_rdata  <= r_err ? '0 : mem[r_idx];
          s_axi_rresp  <= r_err ? 2'b11 : 2'b00;
          s_axi_rlast  <= (r_beat == r_len);
          s_axi_rvalid <= 1'b1;
          r_state      <= R_DATA;
        end
        R_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            if (r_beat == r_len) begin
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_beat <= r_beat + 8'd1;
              if (!r_fixed)
                r_idx <= r_idx + 1'b1;
              r_state <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_slave_ram.sv
// Scoreboard bench for axi4_slave_ram.
// The driver pushes expected B and R responses, computed from a word-array
// reference model. Monitor processes pop and compare those responses as the
// DUT presents them.
module tb_axi4_slave_ram;
  localparam int AW    = 64;
  localparam int DW    = 32;
  localparam int IW    = 1;
  localparam int DEPTH = 4096;

  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } r_exp_t;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic [IW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]    s_axi_awlen, s_axi_arlen;
  logic [1:0]    s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;

  axi4_slave_ram #(
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ID_WIDTH(IW),
    .MEM_DEPTH_WORDS(DEPTH)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 ap_clk = ~ap_clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [DW-1:0]   ref_mem [DEPTH];
  logic [DW-1:0]   wbuf_data [256];
  logic [DW/8-1:0] wbuf_strb [256];
  b_exp_t bq[$];
  r_exp_t rq[$];
  bit rready_hold = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  function automatic int unsigned idx_of(input logic [AW-1:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit addr_err(input logic [AW-1:0] a);
`ifdef AXI_SLAVE_RAM_DECERR_EN
    return (a >> 14) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned beat_idx(input int unsigned base, input int unsigned i,
                                           input logic [1:0] burst);
    return (burst == 2'b00) ? base : (base + i) % DEPTH;
  endfunction

  // Random backpressure on the response channels.
  initial begin
    s_axi_rready = 1'b0;
    s_axi_bready = 1'b0;
    forever begin
      @(posedge ap_clk); #1;
      s_axi_rready = rready_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      s_axi_bready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: compare B responses on handshake, and compare the R beat on every valid cycle (which covers stalls).
  initial begin
    b_exp_t be;
    r_exp_t re;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n) begin
        if (s_axi_bvalid && s_axi_bready) begin
          if (bq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL b_unexpected: got bresp %0h with no response expected", s_axi_bresp);
          end else begin
            be = bq.pop_front();
            check("bid", 64'(s_axi_bid), 64'(be.id));
            check("bresp", 64'(s_axi_bresp), 64'(be.resp));
          end
        end
        if (s_axi_rvalid) begin
          if (rq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL r_unexpected: got rdata %0h with no beat expected", s_axi_rdata);
          end else begin
            re = rq[0];
            check("rdata", 64'(s_axi_rdata), 64'(re.data));
            check("rid", 64'(s_axi_rid), 64'(re.id));
            check("rresp", 64'(s_axi_rresp), 64'(re.resp));
            check("rlast", 64'(s_axi_rlast), 64'(re.last));
            if (s_axi_rready) void'(rq.pop_front());
          end
        end
      end
    end
  end

  task automatic aw_hs(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                       input int unsigned len, input logic [1:0] burst);
    int unsigned k = 0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    forever begin
      @(negedge ap_clk);
      if (s_axi_awready) break;
      if (++k > 500) begin timeout("aw_handshake"); break; end
    end
    @(posedge ap_clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic ar_hs(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                       input int unsigned len, input logic [1:0] burst);
    int unsigned k = 0;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    forever begin
      @(negedge ap_clk);
      if (s_axi_arready) break;
      if (++k > 500) begin timeout("ar_handshake"); break; end
    end
    @(posedge ap_clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  // Send beats [0..n-1] from wbuf, applying each accepted beat to the model.
  task automatic w_beats(input logic [AW-1:0] addr, input int unsigned len,
                         input logic [1:0] burst, input int unsigned n, input bit gaps);
    int unsigned k, g, idx;
    bit err = addr_err(addr);
    for (int unsigned i = 0; i < n; i++) begin
      g = gaps ? $urandom_range(0, 2) : 0;
      repeat (g) begin @(posedge ap_clk); #1; end
      s_axi_wdata = wbuf_data[i]; s_axi_wstrb = wbuf_strb[i];
      s_axi_wlast = (i == len); s_axi_wvalid = 1'b1;
      k = 0;
      forever begin
        @(negedge ap_clk);
        if (s_axi_wready) break;
        if (++k > 500) begin timeout("w_handshake"); break; end
      end
      @(posedge ap_clk); #1;
      s_axi_wvalid = 1'b0;
      if (!err) begin
        idx = beat_idx(idx_of(addr), i, burst);
        for (int unsigned b = 0; b < DW / 8; b++)
          if (wbuf_strb[i][b]) ref_mem[idx][b*8 +: 8] = wbuf_data[i][b*8 +: 8];
      end
    end
  endtask

  task automatic write_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input int unsigned len, input logic [1:0] burst, input bit gaps);
    int unsigned k = 0;
    bq.push_back('{id: id, resp: addr_err(addr) ? 2'b11 : 2'b00});
    aw_hs(id, addr, len, burst);
    w_beats(addr, len, burst, len + 1, gaps);
    while (bq.size() != 0) begin
      @(posedge ap_clk);
      if (++k > 500) begin timeout("b_response"); bq.delete(); end
    end
    #1;
  endtask

  task automatic read_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input int unsigned len, input logic [1:0] burst, input bit chk_ar);
    int unsigned k = 0;
    bit err = addr_err(addr);
    for (int unsigned i = 0; i <= len; i++)
      rq.push_back('{id: id, data: err ? '0 : ref_mem[beat_idx(idx_of(addr), i, burst)],
                     resp: err ? 2'b11 : 2'b00, last: (i == len)});
    ar_hs(id, addr, len, burst);
    while (rq.size() != 0) begin
      @(negedge ap_clk);
      if (chk_ar && rq.size() != 0) check("arready_busy", 64'(s_axi_arready), 64'd0);
      if (++k > 8 * (len + 1) + 200) begin timeout("r_burst"); rq.delete(); end
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic single_write(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                              input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    wbuf_data[0] = d; wbuf_strb[0] = s;
    write_burst(id, addr, 0, 2'b01, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k, len;
    logic [AW-1:0] a;
    logic [1:0] bt;
    ap_rst_n = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arburst = '0; s_axi_arvalid = 1'b0;
    repeat (2) @(posedge ap_clk); #1;
    check("rst_awready", 64'(s_axi_awready), 64'd1);
    check("rst_arready", 64'(s_axi_arready), 64'd1);
    check("rst_wready", 64'(s_axi_wready), 64'd0);
    check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst_rlast", 64'(s_axi_rlast), 64'd0);
    check("rst_rdata", 64'(s_axi_rdata), 64'd0);
    check("rst_bresp_rresp", 64'({s_axi_bresp, s_axi_rresp}), 64'd0);
    check("rst_bid_rid", 64'({s_axi_bid, s_axi_rid}), 64'd0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // Fill the whole RAM with 256-beat INCR bursts so every model word is known.
    for (int unsigned blk = 0; blk < DEPTH / 256; blk++) begin
      for (int unsigned i = 0; i < 256; i++) begin
        wbuf_data[i] = $urandom; wbuf_strb[i] = '1;
      end
      write_burst(IW'(blk), AW'(blk * 1024), 255, 2'b01, 1'b0);
    end

    // Single write, then read it back.
    single_write(1'b1, 64'h10, 32'hDEADBEEF, 4'hF);
    read_burst(1'b1, 64'h10, 0, 2'b01, 1'b1);

    // 16-beat INCR burst with gaps on the W channel.
    for (int unsigned i = 0; i < 16; i++) begin wbuf_data[i] = i; wbuf_strb[i] = '1; end
    write_burst(1'b0, 64'h0, 15, 2'b01, 1'b1);
    read_burst(1'b0, 64'h0, 15, 2'b01, 1'b1);

    // Byte strobes.
    single_write(1'b0, 64'h20, 32'h11223344, 4'hF);
    single_write(1'b1, 64'h20, 32'hAABBCCDD, 4'h5);
    read_burst(1'b1, 64'h20, 0, 2'b01, 1'b0);

    // 8-beat read under random rready.
    read_burst(1'b0, 64'h0, 7, 2'b01, 1'b1);

    // FIXED burst: the last beat wins.
    for (int unsigned i = 0; i < 4; i++) begin wbuf_data[i] = i + 1; wbuf_strb[i] = '1; end
    write_burst(1'b0, 64'h40, 3, 2'b00, 1'b1);
    read_burst(1'b0, 64'h40, 0, 2'b01, 1'b0);
    read_burst(1'b1, 64'h40, 2, 2'b00, 1'b0);

    // Burst crossing the top of the RAM wraps to index 0.
    for (int unsigned i = 0; i < 4; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = '1; end
    write_burst(1'b1, AW'((DEPTH - 2) * 4), 3, 2'b01, 1'b0);
    read_burst(1'b1, AW'((DEPTH - 2) * 4), 3, 2'b10, 1'b0);

    // Randomized transactions, some with upper address bits set.
    for (int unsigned t = 0; t < 24; t++) begin
      a = AW'(($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a[$urandom_range(14, AW - 1)] = 1'b1;
      len = $urandom_range(0, 15);
      bt = 2'($urandom_range(0, 2));
      for (int unsigned i = 0; i <= len; i++) begin
        wbuf_data[i] = $urandom; wbuf_strb[i] = 4'($urandom);
      end
      write_burst(IW'($urandom), a, len, bt, 1'b1);
      read_burst(IW'($urandom), a, len, bt, 1'($urandom));
    end

    // Reset in the middle of a stalled read burst and a partial write burst.
    rready_hold = 1'b1;
    for (int unsigned i = 0; i < 8; i++)
      rq.push_back('{id: 1'b1, data: ref_mem[i], resp: 2'b00, last: (i == 7)});
    ar_hs(1'b1, 64'h0, 7, 2'b01);
    k = 0;
    while (!s_axi_rvalid && k < 50) begin @(posedge ap_clk); #1; k++; end
    if (!s_axi_rvalid) timeout("rvalid_before_reset");
    bq.push_back('{id: 1'b0, resp: 2'b00});
    aw_hs(1'b0, 64'h100, 7, 2'b01);
    for (int unsigned i = 0; i < 3; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = '1; end
    w_beats(64'h100, 7, 2'b01, 3, 1'b0);
    @(negedge ap_clk); #2;
    ap_rst_n = 1'b0;
    #1;
    check("midrst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("midrst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("midrst_wready", 64'(s_axi_wready), 64'd0);
    check("midrst_awready", 64'(s_axi_awready), 64'd1);
    rq.delete();
    bq.delete();
    rready_hold = 1'b0;
    repeat (2) @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    single_write(1'b1, 64'h104, 32'hCAFEF00D, 4'hF);
    read_burst(1'b0, 64'h100, 7, 2'b01, 1'b1);

`ifdef AXI_SLAVE_RAM_DECERR_EN
    single_write(1'b1, 64'h1_0000_0000, 32'h12345678, 4'hF);
    read_burst(1'b0, 64'h0, 0, 2'b01, 1'b0);
    read_burst(1'b1, 64'h1_0000_0000, 1, 2'b01, 1'b0);
`endif

    k = 0;
    while ((rq.size() != 0 || bq.size() != 0) && k < 200) begin @(posedge ap_clk); k++; end
    if (rq.size() != 0 || bq.size() != 0) timeout("drain");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4_slave_ram.md
Name: axi4_slave_ram

Overview:
- AXI4 memory-mapped slave (responder) backed by on-chip dual-port RAM.
- It is the far end of the kernel's m00_axi/m01_axi master ports. Benches and the RISC-V subsystem use it as instruction/data memory behind the 1x2 interconnect.
- Supports single and INCR/FIXED bursts up to 256 beats.
- Read and write channels are fully independent, with one outstanding transaction per direction.

Parameters:
- C_S_AXI_ADDR_WIDTH, 64, byte address width.
- C_S_AXI_DATA_WIDTH, 32, data width; allowed values 32, 64, 128, 256, 512.
- C_S_AXI_ID_WIDTH, 1, width of the AXI ID signals.
- MEM_DEPTH_WORDS, 4096, RAM depth in data words; must be a power of 2.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  reset; asynchronous assert, active-low.
- s_axi_awid  in  ID  write ID.
- s_axi_awaddr  in  ADDR  write byte address.
- s_axi_awlen  in  8  write burst length minus 1.
- s_axi_awburst  in  2  write burst type.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  DATA  write data.
- s_axi_wstrb  in  DATA/8  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bid  out  ID  response ID.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_arid  in  ID  read ID.
- s_axi_araddr  in  ADDR  read byte address.
- s_axi_arlen  in  8  read burst length minus 1.
- s_axi_arburst  in  2  read burst type.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rid  out  ID  read ID.
- s_axi_rdata  out  DATA  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rlast  out  1  last read beat.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.

Behaviour:
- Reset (ap_rst_n=0, asynchronous):
  - Both FSMs go to IDLE.
  - bvalid=0, rvalid=0, rlast=0, wready=0.
  - awready=1 and arready=1.
  - bid/rid/bresp/rresp/rdata=0.
  - RAM contents are not cleared.
  - Reset mid-burst abandons the burst; no response is issued.
- Address handling:
  - Word index = addr[ADDR_LSB +: log2(MEM_DEPTH_WORDS)], with ADDR_LSB = log2(DATA/8).
  - Low address bits are ignored, so every beat is full-width.
  - Burst type FIXED (2'b00): index is held constant.
  - INCR (2'b01) and WRAP (2'b10, treated as INCR): index increments by 1 per beat and wraps modulo MEM_DEPTH_WORDS.
  - Size signals are not present; the width is always DATA.
- Write FSM:
  - W_IDLE (awready=1): on awvalid&awready, latch id, index, len and burst type, and clear the beat counter. Go to W_DATA; awready drops the next cycle.
  - W_DATA (wready=1): each wvalid&wready writes wdata into RAM, gated per byte by wstrb.
  - The burst ends when the beat counter equals the latched len; wlast is not used for termination.
  - On the final beat go to W_RESP.
  - W_RESP: bvalid=1, bid = latched id, bresp=OKAY (2'b00). On bready, return to W_IDLE.
  - A new AW may be accepted in the cycle after the B handshake.
- Read FSM:
  - R_IDLE (arready=1): on handshake, latch id, index, len and burst type; go to R_FETCH.
  - R_FETCH: RAM read issued (1-cycle registered read); go to R_DATA.
  - R_DATA: rvalid=1 with rid = latched id. rlast=1 on beat len. rdata is held stable while rready=0.
  - On handshake: if it was the last beat go to R_IDLE, otherwise advance the index and go to R_FETCH.
  - Throughput is one beat per 2 cycles.
- Read/write collision: a read and write to the same word in the same cycle returns the old data (read-first).
- awlen=0 and arlen=0 are single-beat transfers, with rlast=1 on that beat.
- A burst that crosses the top of the RAM wraps to index 0 (no error without the optional feature).

Optional Feature:
- Macro AXI_SLAVE_RAM_DECERR_EN.
- Defined:
  - Any address whose bits above the RAM range are nonzero is an error transaction.
  - Writes: strobes are suppressed for the whole burst; bresp=DECERR (2'b11).
  - Reads: rdata=0 and rresp=DECERR on every beat.
  - The error decision is made once, at AW/AR acceptance.
- Not defined: upper address bits are ignored (aliasing) and all responses are OKAY.

Test Plan:
- Single write: AW addr 0x10, len 0; W 0xDEADBEEF, wstrb 0xF -> B bresp 0, bid matches. Then AR 0x10 len 0 -> rdata 0xDEADBEEF, rlast=1.
- INCR write burst: AW addr 0x0, len 15; data 0..15 with random wvalid gaps -> single B response. Read-back: 16 beats of 0..15, rlast only on beat 16.
- Byte strobes: word at 0x20 holds 0x11223344; write 0xAABBCCDD with wstrb 0x5 -> read returns 0x11BB33DD.
- Backpressure: rready toggled randomly during an 8-beat read -> rdata stable while stalled; no beats lost or duplicated; arready=0 until the burst ends.
- FIXED burst of 4 beats writing 1,2,3,4 to 0x40 -> read 0x40 returns 4. Separately, reset asserted mid-burst -> bvalid=0 and rvalid=0 immediately, and a fresh AW is accepted after release.
- With AXI_SLAVE_RAM_DECERR_EN: write to 0x1_0000_0000 -> bresp=3; a read of the aliased low address shows the contents unchanged.
